// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (00.00-99.99 s) with start/pause and clear buttons.
// Define BCD_STOPWATCH_DEBOUNCE_EN to build the debounce counters; otherwise buttons are only synchronised.
module bcd_stopwatch #(
  parameter int TICK_DIV        = 1000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [23:0] TICK_MAX = 24'(TICK_DIV - 1);
`ifdef BCD_STOPWATCH_DEBOUNCE_EN
  localparam logic [23:0] DEB_MAX = 24'(DEBOUNCE_CYCLES - 1);
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;

  assign btn_raw = {btn_clear, btn_start};

  // Per button: 2-flop synchroniser, optional debounce, registered rising-edge pulse.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q, sync1_d;
      logic sync2_q, sync2_d;
      logic prev_q, prev_d;
      logic pulse_q, pulse_d;
      logic level;

`ifdef BCD_STOPWATCH_DEBOUNCE_EN
      logic        level_q, level_d;
      logic [23:0] cnt_q, cnt_d;

      always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
          if (cnt_q == DEB_MAX) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 24'd1;
          end
        end
      end

      always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
          level_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          level_q <= level_d;
          cnt_q   <= cnt_d;
        end
      end

      assign level = level_q;
`else
      assign level = sync2_q;
`endif

      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        prev_d  = level;
        pulse_d = level & ~prev_q;
      end

      always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
          prev_q  <= 1'b0;
          pulse_q <= 1'b0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          prev_q  <= prev_d;
          pulse_q <= pulse_d;
        end
      end

      assign btn_pulse[gi] = pulse_q;
    end
  endgenerate

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [15:0] digits_q, digits_d;
  logic        wrap_q, wrap_d;
  logic        start_p, clear_p, tick;

  assign start_p = btn_pulse[0];
  assign clear_p = btn_pulse[1];
  assign tick    = (state_q == RUN) && (presc_q == TICK_MAX);

  // Start has priority only in RUN; elsewhere clear wins.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!clear_p && start_p) state_d = RUN;
      RUN:     if (start_p) state_d = PAUSE;
      PAUSE: begin
        if (clear_p) begin
          state_d = IDLE;
        end else if (start_p) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin : p_count
    logic carry;
    carry    = tick;
    digits_d = digits_q;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digits_q[4*i +: 4] == 4'd9) begin
          digits_d[4*i +: 4] = 4'd0;
        end else begin
          digits_d[4*i +: 4] = digits_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    wrap_d = carry;

    // Prescaler holds through PAUSE so the partial tick survives a pause.
    presc_d = presc_q;
    if (state_q == RUN) begin
      presc_d = tick ? 24'd0 : presc_q + 24'd1;
    end
    if (state_d == IDLE) begin
      presc_d  = '0;
      digits_d = '0;
      wrap_d   = 1'b0;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  assign digits  = digits_q;
  assign running = (state_q == RUN);
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch: stimulus queues expected output changes with the cycle they must occur on.
module tb_bcd_stopwatch;

  localparam int TD = 4;
  localparam int DC = 8;
`ifdef BCD_STOPWATCH_DEBOUNCE_EN
  localparam int LAT = DC + 4;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start;
  logic        btn_clear;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  bcd_stopwatch #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .btn_start    (btn_start),
    .btn_clear    (btn_clear),
    .digits       (digits),
    .running      (running),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stamp;
    logic        run;
    logic        wr;
    logic [15:0] dig;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;
  logic [17:0] prev = '0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  function automatic logic [15:0] bcd(input int n);
    bcd = {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic expect_ev(input int st, input logic r, input logic w, input logic [15:0] d);
    ev_t e;
    e.stamp = st;
    e.run   = r;
    e.wr    = w;
    e.dig   = d;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, got, want);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every change of the outputs is one transaction, matched against the queue.
  initial begin : monitor
    logic [17:0] cur;
    ev_t         e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur = {running, wrap, digits};
        if (cur !== prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change: cycle %0d run=%0b wrap=%0b digits=%h, required no change",
                     cyc, running, wrap, digits);
          end else begin
            e = exp_q.pop_front();
            if (e.stamp == cyc && e.run === running && e.wr === wrap && e.dig === digits) begin
              passes++;
              $display("event cycle %0d run=%0b wrap=%0b digits=%h ok", cyc, running, wrap, digits);
            end else begin
              $display("FAIL event: got cycle %0d run=%0b wrap=%0b digits=%h, required cycle %0d run=%0b wrap=%0b digits=%h",
                       cyc, running, wrap, digits, e.stamp, e.run, e.wr, e.dig);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin : stimulus
    int p, r, s, u, v;
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_digits", 32'(digits), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_wrap", 32'(wrap), 32'h0);
    prev   = '0;
    mon_en = 1'b1;
    wait_cyc(cyc + 100);

`ifdef BCD_STOPWATCH_DEBOUNCE_EN
    // Glitch shorter than the debounce window: no change may appear.
    btn_start = 1'b1;
    wait_cyc(cyc + 5);
    btn_start = 1'b0;
    wait_cyc(cyc + 40);
`endif

    // Start, count to 12, pause two prescaler cycles after the 12th tick.
    p = cyc;
    r = p + LAT;
    expect_ev(r, 1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 12; k++) expect_ev(r + TD * k, 1'b1, 1'b0, bcd(k));
    s = r + 12 * TD + 2;
    expect_ev(s, 1'b0, 1'b0, 16'h0012);
    btn_start = 1'b1;
    wait_cyc(p + 20);
    btn_start = 1'b0;

    wait_cyc(s - LAT);
    btn_start = 1'b1;
    wait_cyc(s - LAT + 500);
    btn_start = 1'b0;

    // Resume: next increment two RUN cycles later, then every TD; pause at 40.
    wait_cyc(s - LAT + 520);
    u = cyc + LAT;
    expect_ev(u, 1'b1, 1'b0, 16'h0012);
    for (int k = 13; k <= 40; k++) expect_ev(u + 2 + TD * (k - 13), 1'b1, 1'b0, bcd(k));
    v = u + 2 + TD * 27 + 1;
    expect_ev(v, 1'b0, 1'b0, 16'h0040);
    btn_start = 1'b1;
    wait_cyc(u - LAT + 20);
    btn_start = 1'b0;

    // Clear while running is ignored.
    wait_cyc(u + 20);
    btn_clear = 1'b1;
    wait_cyc(u + 40);
    btn_clear = 1'b0;

    wait_cyc(v - LAT);
    btn_start = 1'b1;
    wait_cyc(v - LAT + 20);
    btn_start = 1'b0;

    // Clear and start together while paused: clear wins.
    wait_cyc(v + 30);
    expect_ev(v + 30 + LAT, 1'b0, 1'b0, 16'h0000);
    btn_start = 1'b1;
    btn_clear = 1'b1;
    wait_cyc(v + 50);
    btn_start = 1'b0;
    btn_clear = 1'b0;

    // Full run through 99.99 and the rollover.
    wait_cyc(v + 100);
    r = cyc + LAT;
    expect_ev(r, 1'b1, 1'b0, 16'h0000);
    for (int k = 1; k <= 9999; k++) expect_ev(r + TD * k, 1'b1, 1'b0, bcd(k));
    expect_ev(r + TD * 10000, 1'b1, 1'b1, 16'h0000);
    expect_ev(r + TD * 10000 + 1, 1'b1, 1'b0, 16'h0000);
    expect_ev(r + TD * 10001, 1'b1, 1'b0, 16'h0001);
    expect_ev(r + TD * 10002, 1'b1, 1'b0, 16'h0002);
    btn_start = 1'b1;
    wait_cyc(cyc + 20);
    btn_start = 1'b0;

    // Asynchronous reset mid-cycle while counting.
    wait_cyc(r + TD * 10002 + 1);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    check("async_reset_digits", 32'(digits), 32'h0);
    check("async_reset_running", 32'(running), 32'h0);
    check("async_reset_wrap", 32'(wrap), 32'h0);
    check("events_outstanding", 32'(exp_q.size()), 32'h0);

    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    prev   = '0;
    mon_en = 1'b1;
    wait_cyc(cyc + 50);
    check("after_reset_running", 32'(running), 32'h0);
    check("after_reset_digits", 32'(digits), 32'h0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
